// File: rtl/uart_tx_fifo_param_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity encodings,
// FSM state encoding and the elaboration-time parameter legality check.
package uart_tx_fifo_param_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    function automatic bit params_ok(input int clks_per_bit, input int data_bits,
                                     input int parity_mode, input int stop_bits,
                                     input int fifo_depth);
        return (clks_per_bit >= 2) &&
               (data_bits >= 5) && (data_bits <= 9) &&
               (parity_mode >= PARITY_NONE) && (parity_mode <= PARITY_EVEN) &&
               ((stop_bits == 1) || (stop_bits == 2)) &&
               (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// Write-side and line-side signals of the UART transmitter; the producer uses
// the master modport, the transmitter the slave modport.
interface uart_tx_fifo_param_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                 tx_dv;
    logic [DATA_BITS-1:0] tx_byte;
    logic                 tx_ready;
    logic [COUNT_W-1:0]   fifo_count;
    logic                 tx_active;
    logic                 tx_serial;
    logic                 tx_done;

    modport master (
        output tx_dv, tx_byte,
        input  tx_ready, fifo_count, tx_active, tx_serial, tx_done
    );

    modport slave (
        input  tx_dv, tx_byte,
        output tx_ready, fifo_count, tx_active, tx_serial, tx_done
    );

endinterface

// File: rtl/uart_tx_fifo_param_fifo.sv
// Small synchronous FIFO with a show-ahead head: rd_data is the oldest word
// whenever the FIFO is not empty, so the consumer pops and uses it in one cycle.
module uart_tx_fifo_param_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push;
    logic             pop;

    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign full    = (count_reg == (AW + 1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with input FIFO; frames are chained back to
// back whenever a word is queued at the end of the stop period.
module uart_tx_fifo_param
    import uart_tx_fifo_param_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PARITY_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_fifo_param_if.slave  bus
);
    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int IDX_W   = $clog2(DATA_BITS);
    localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

    if (!params_ok(CLKS_PER_BIT, DATA_BITS, PARITY_MODE, STOP_BITS, FIFO_DEPTH)) begin : g_bad_params
        $error("uart_tx_fifo_param: illegal parameter combination");
    end

    tx_state_t            state_reg;
    tx_state_t            state_next;
    logic [CNT_W-1:0]     clk_cnt_reg;
    logic [IDX_W-1:0]     bit_idx_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 serial_reg;
    logic                 serial_next;
    logic                 done_reg;
    logic                 active_reg;
    logic                 frame_end_reg;

    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;
    logic                 frame_end;
    logic                 parity_bit;
    logic                 pop;
    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;
    logic [COUNT_W-1:0]   fifo_count;

    assign push = bus.tx_dv && !fifo_full;

    uart_tx_fifo_param_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (bus.tx_byte),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bit_end    = (clk_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
    assign last_data  = (bit_idx_reg == IDX_W'(DATA_BITS - 1));
    assign last_stop  = (bit_idx_reg == IDX_W'(STOP_BITS - 1));
    assign frame_end  = (state_reg == ST_STOP) && bit_end && last_stop;
    assign parity_bit = (PARITY_MODE == PARITY_EVEN) ? ^data_reg : ~^data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (!fifo_empty) state_next = ST_START;
            ST_START:  if (bit_end) state_next = ST_DATA;
            ST_DATA:   if (bit_end && last_data)
                           state_next = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_next = ST_STOP;
            ST_STOP:   if (frame_end) state_next = fifo_empty ? ST_IDLE : ST_START;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        serial_next = 1'b1;
        pop         = 1'b0;
        case (state_reg)
            ST_IDLE:   pop = !fifo_empty;
            ST_START:  serial_next = 1'b0;
            ST_DATA:   serial_next = data_reg[bit_idx_reg];
            ST_PARITY: serial_next = parity_bit;
            ST_STOP:   pop = frame_end && !fifo_empty;
            default:   serial_next = 1'b1;
        endcase
    end

    // The line lags the FSM by one register stage, so Done and the Active
    // drop are delayed one extra cycle to line up with the end of the stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_cnt_reg   <= '0;
            bit_idx_reg   <= '0;
            data_reg      <= '0;
            serial_reg    <= 1'b1;
            done_reg      <= 1'b0;
            active_reg    <= 1'b0;
            frame_end_reg <= 1'b0;
        end else begin
            serial_reg    <= serial_next;
            frame_end_reg <= frame_end;
            done_reg      <= frame_end_reg;

            if ((state_reg == ST_IDLE) || bit_end) begin
                clk_cnt_reg <= '0;
            end else begin
                clk_cnt_reg <= clk_cnt_reg + 1'b1;
            end

            if ((state_reg == ST_DATA) && bit_end) begin
                bit_idx_reg <= last_data ? '0 : bit_idx_reg + 1'b1;
            end else if ((state_reg == ST_STOP) && bit_end) begin
                bit_idx_reg <= last_stop ? '0 : bit_idx_reg + 1'b1;
            end

            if (pop) begin
                data_reg   <= fifo_head;
                active_reg <= 1'b1;
            end else if (frame_end_reg && (state_reg == ST_IDLE)) begin
                active_reg <= 1'b0;
            end
        end
    end

    assign bus.tx_serial  = serial_reg;
    assign bus.tx_done    = done_reg;
    assign bus.tx_active  = active_reg;
    assign bus.tx_ready   = !fifo_full;
    assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param: several parameter variants share one
// clock and reset; a line monitor decodes frames of the selected instance.
module tb_uart_tx_fifo_param;

    logic       clk;
    logic       rst;
    logic [4:0] dv;
    logic [8:0] wbyte;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_fifo_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if0 ();
    uart_tx_fifo_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if1 ();
    uart_tx_fifo_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if2 ();
    uart_tx_fifo_param_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if3 ();
    uart_tx_fifo_param_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if4 ();

    assign if0.tx_dv = dv[0];  assign if0.tx_byte = wbyte[7:0];
    assign if1.tx_dv = dv[1];  assign if1.tx_byte = wbyte[7:0];
    assign if2.tx_dv = dv[2];  assign if2.tx_byte = wbyte[7:0];
    assign if3.tx_dv = dv[3];  assign if3.tx_byte = wbyte[6:0];
    assign if4.tx_dv = dv[4];  assign if4.tx_byte = wbyte[6:0];

    uart_tx_fifo_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    uart_tx_fifo_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    uart_tx_fifo_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    uart_tx_fifo_param #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4))
        u_dut3 (.clk(clk), .rst(rst), .bus(if3));
    uart_tx_fifo_param #(.CLKS_PER_BIT(10416), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4))
        u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         sel;
    logic       m_serial, m_done, m_active, m_ready;
    logic [2:0] m_count;

    always_comb begin
        m_serial = if0.tx_serial; m_done = if0.tx_done; m_active = if0.tx_active;
        m_ready  = if0.tx_ready;  m_count = if0.fifo_count;
        case (sel)
            1: begin m_serial = if1.tx_serial; m_done = if1.tx_done; m_active = if1.tx_active;
                     m_ready = if1.tx_ready; m_count = if1.fifo_count; end
            2: begin m_serial = if2.tx_serial; m_done = if2.tx_done; m_active = if2.tx_active;
                     m_ready = if2.tx_ready; m_count = if2.fifo_count; end
            3: begin m_serial = if3.tx_serial; m_done = if3.tx_done; m_active = if3.tx_active;
                     m_ready = if3.tx_ready; m_count = if3.fifo_count; end
            4: begin m_serial = if4.tx_serial; m_done = if4.tx_done; m_active = if4.tx_active;
                     m_ready = if4.tx_ready; m_count = if4.fifo_count; end
            default: ;
        endcase
    end

    // Line monitor: samples every bit cell on each negedge and requires it constant.
    int          mon_cpb, mon_nbits, cyc;
    logic        rx_busy;
    int          rx_cnt, glitches, inactive, max_count;
    logic [15:0] rx_bits;
    logic [15:0] frame_q[$];
    int          start_q[$];
    int          done_q[$];

    initial begin
        cyc = 0; rx_busy = 1'b0; rx_cnt = 0; rx_bits = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (int'(m_count) > max_count) max_count = int'(m_count);
            if (m_done) done_q.push_back(cyc);
            if (rst) begin
                rx_busy = 1'b0;
            end else begin
                if (!rx_busy && (m_serial == 1'b0)) begin
                    rx_busy = 1'b1; rx_cnt = 0; rx_bits = '0;
                    start_q.push_back(cyc);
                end
                if (rx_busy) begin
                    if (!m_active) inactive++;
                    if ((rx_cnt % mon_cpb) == 0) rx_bits[rx_cnt / mon_cpb] = m_serial;
                    else if (m_serial !== rx_bits[rx_cnt / mon_cpb]) glitches++;
                    rx_cnt++;
                    if (rx_cnt == mon_cpb * mon_nbits) begin
                        frame_q.push_back(rx_bits);
                        rx_busy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic [8:0] b);
        dv[idx] = 1'b1;
        wbyte   = b;
        tick();
        dv = '0;
    endtask

    task automatic mon_setup(input int s, input int cpb, input int nbits);
        sel = s; mon_cpb = cpb; mon_nbits = nbits;
        frame_q.delete(); start_q.delete(); done_q.delete();
        rx_busy = 1'b0; glitches = 0; inactive = 0; max_count = 0;
    endtask

    task automatic wait_dones(input string tag, input int n, input int limit);
        for (int i = 0; (i < limit) && (done_q.size() < n); i++) tick();
        check(tag, done_q.size(), n);
    endtask

    function automatic logic [15:0] frame_at(input int i);
        return (i < frame_q.size()) ? frame_q[i] : 16'hFFFF;
    endfunction

    function automatic int start_at(input int i);
        return (i < start_q.size()) ? start_q[i] : -1000;
    endfunction

    function automatic int done_at(input int i);
        return (i < done_q.size()) ? done_q[i] : -5000;
    endfunction

    initial begin
        int n;
        int lows;
        rst = 1'b1; dv = '0; wbyte = '0;
        mon_setup(0, 4, 10);
        repeat (3) tick();

        check("rst_serial", 32'(m_serial), 1);
        check("rst_ready",  32'(m_ready),  1);
        check("rst_count",  32'(m_count),  0);
        check("rst_active", 32'(m_active), 0);
        check("rst_done",   32'(m_done),   0);
        rst = 1'b0;
        tick();

        // 8N1 single frame with latency checks
        send(0, 9'h0A5);
        check("t1_count_n",   32'(m_count),  1);
        check("t1_serial_n",  32'(m_serial), 1);
        tick();
        check("t1_count_n1",  32'(m_count),  0);
        check("t1_active_n1", 32'(m_active), 1);
        check("t1_serial_n1", 32'(m_serial), 1);
        tick();
        check("t1_serial_n2", 32'(m_serial), 0);
        wait_dones("t1_done_seen", 1, 100);
        check("t1_frame",     32'(frame_at(0)), 32'h34A);
        check("t1_len",       32'(done_at(0) - start_at(0)), 40);
        check("t1_glitch",    32'(glitches), 0);
        check("t1_done_low",  32'(m_done),   0);
        check("t1_active_lo", 32'(m_active), 0);
        repeat (20) tick();
        check("t1_one_done",  done_q.size(), 1);

        // parity variants
        mon_setup(1, 4, 11);
        send(1, 9'h007);
        wait_dones("t2e_done_seen", 1, 100);
        check("t2e_frame", 32'(frame_at(0)), 32'h60E);
        check("t2e_len",   32'(done_at(0) - start_at(0)), 44);
        check("t2e_glitch", 32'(glitches), 0);
        mon_setup(2, 4, 11);
        send(2, 9'h007);
        wait_dones("t2o_done_seen", 1, 100);
        check("t2o_frame", 32'(frame_at(0)), 32'h40E);
        check("t2o_len",   32'(done_at(0) - start_at(0)), 44);

        // back-to-back frames
        mon_setup(0, 4, 10);
        send(0, 9'h011); send(0, 9'h022); send(0, 9'h033);
        wait_dones("t3_done_seen", 3, 300);
        check("t3_frame0", 32'(frame_at(0)), 32'h222);
        check("t3_frame1", 32'(frame_at(1)), 32'h244);
        check("t3_frame2", 32'(frame_at(2)), 32'h266);
        check("t3_gap01",  32'(start_at(1) - start_at(0)), 40);
        check("t3_gap12",  32'(start_at(2) - start_at(1)), 40);
        check("t3_done01", 32'(done_at(1) - done_at(0)), 40);
        check("t3_len0",   32'(done_at(0) - start_at(0)), 40);
        check("t3_glitch", 32'(glitches), 0);
        check("t3_inactive", 32'(inactive), 0);
        tick();
        check("t3_active_end", 32'(m_active), 0);

        // overflow: sixth word dropped
        mon_setup(0, 4, 10);
        for (int i = 0; i < 6; i++) begin
            dv[0] = 1'b1;
            wbyte = 9'(i + 1);
            if (i == 5) begin
                check("t4_ready_full", 32'(m_ready), 0);
                check("t4_count_full", 32'(m_count), 4);
            end
            tick();
        end
        dv = '0;
        check("t4_count_drop", 32'(m_count), 4);
        wait_dones("t4_done_seen", 5, 400);
        repeat (60) tick();
        check("t4_frames", frame_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_frame%0d", i), 32'(frame_at(i)), 32'h200 | ((i + 1) << 1));
        end
        check("t4_max_count", 32'(max_count), 4);

        // reset during data bit 3 with two words queued
        mon_setup(0, 4, 10);
        send(0, 9'h000); send(0, 9'h000); send(0, 9'h000);
        repeat (17) tick();
        check("t5_pre_serial", 32'(m_serial), 0);
        check("t5_pre_count",  32'(m_count),  2);
        rst = 1'b1;
        #1;
        check("t5_serial", 32'(m_serial), 1);
        check("t5_count",  32'(m_count),  0);
        check("t5_active", 32'(m_active), 0);
        check("t5_ready",  32'(m_ready),  1);
        check("t5_done",   32'(m_done),   0);
        repeat (2) tick();
        rst = 1'b0;
        mon_setup(0, 4, 10);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (m_serial == 1'b0) lows++;
        end
        check("t5_idle_lows", 32'(lows), 0);
        check("t5_no_done",   done_q.size(), 0);

        // 7 data bits, 2 stop bits
        mon_setup(3, 3, 10);
        send(3, 9'h055);
        wait_dones("t6_done_seen", 1, 100);
        check("t6_frame",  32'(frame_at(0)), 32'h3AA);
        check("t6_len",    32'(done_at(0) - start_at(0)), 30);
        check("t6_glitch", 32'(glitches), 0);

        // full-size bit period: counter must not wrap
        mon_setup(4, 10416, 10);
        send(4, 9'h055);
        for (int i = 0; (i < 10) && (m_serial != 1'b0); i++) tick();
        check("t6b_start_seen", 32'(m_serial), 0);
        n = 0;
        for (int i = 0; (i < 20000) && (m_serial == 1'b0); i++) begin n++; tick(); end
        check("t6b_start_len", 32'(n), 10416);
        n = 0;
        for (int i = 0; (i < 20000) && (m_serial == 1'b1); i++) begin n++; tick(); end
        check("t6b_bit0_len", 32'(n), 10416);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
